// File: rtl/l2cache_pkg.sv
// Shared types, widths and helpers for the N-way set-associative L2 cache.
package l2cache_pkg;

    localparam int LINE_W         = 128;
    localparam int WORD_W         = 32;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFFSET_W       = $clog2(WORDS_PER_LINE);

    typedef enum logic [2:0] {IDLE, WB, RD, FL, FLWB} state_t;

    // Index bits taken from the word address for a given set count.
    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits left over once the word offset and set index are removed.
    function automatic int tag_width(input int addr_w, input int sets);
        return addr_w - OFFSET_W - $clog2(sets);
    endfunction

    // Replace one 32-bit word of a line, used for write hits and write-miss fills.
    function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                     input logic [OFFSET_W-1:0] sel,
                                                     input logic [WORD_W-1:0] word);
        logic [LINE_W-1:0] merged;
        merged = line;
        merged[sel*WORD_W +: WORD_W] = word;
        return merged;
    endfunction

endpackage

// File: rtl/l2cache_nway_lru.sv
// l2_lru_age: true-LRU age update for one set; ages stay a permutation of 0..WAYS-1.
module l2_lru_age #(
    parameter int WAYS  = 4,
    parameter int AGE_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0][AGE_W-1:0] age_in,
    input  logic [AGE_W-1:0]           touch_way,
    output logic [WAYS-1:0][AGE_W-1:0] age_out,
    output logic [AGE_W-1:0]           lru_way
);

    // Younger-than-touched ways age by one, the touched way becomes 0; oldest way is the LRU.
    // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
    always_comb begin
        age_out = age_in;
        lru_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (age_in[i] < age_in[touch_way]) age_out[i] = age_in[i] + 1'b1;
            if (age_in[i] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(i);
        end
        age_out[touch_way] = '0;
    end

endmodule

// File: rtl/l2cache_nway.sv
// l2cache_nway: N-way set-associative write-back/write-allocate L2 with true LRU and whole-cache flush.
module l2cache_nway
    import l2cache_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int SETS   = 16,
    parameter int ADDR_W = 30
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              proc_read,
    input  logic              proc_write,
    input  logic [ADDR_W-1:0] proc_addr,
    input  logic [WORD_W-1:0] proc_wdata,
    output logic [WORD_W-1:0] proc_rdata,
    output logic              proc_stall,
    input  logic              flush,
    output logic              flush_done,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int IDX_W = idx_width(SETS);
    localparam int TAG_W = tag_width(ADDR_W, SETS);
    localparam int AGE_W = $clog2(WAYS);

    // Line storage and per-set bookkeeping.
    logic [WAYS-1:0]             valid_q [SETS];
    logic [WAYS-1:0]             dirty_q [SETS];
    logic [WAYS-1:0][AGE_W-1:0]  age_q   [SETS];
    logic [TAG_W-1:0]            tag_q   [SETS][WAYS];
    logic [LINE_W-1:0]           data_q  [SETS][WAYS];

    state_t            state_q, state_d;
    logic [AGE_W-1:0]  victim_q, victim_d, victim_way, hit_way, lru_way, touch_way;
    logic [IDX_W-1:0]  fl_set_q, fl_set_d, fl_set_nx;
    logic [AGE_W-1:0]  fl_way_q, fl_way_d, fl_way_nx;
    logic              fl_last, hit;
    logic              mem_read_d, mem_write_d, flush_done_d;
    logic [ADDR_W-3:0] mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_d, hit_line;
    logic              hit_touch_en, hit_wr_en, fill_en, fl_clean_en;
    logic [WAYS-1:0][AGE_W-1:0] age_next;

    logic [IDX_W-1:0]    set_idx;
    logic [TAG_W-1:0]    tag;
    logic [OFFSET_W-1:0] word_sel;

    assign set_idx  = proc_addr[IDX_W+OFFSET_W-1:OFFSET_W];
    assign tag      = proc_addr[ADDR_W-1:IDX_W+OFFSET_W];
    assign word_sel = proc_addr[OFFSET_W-1:0];

    // Tag compare across the indexed set; at most one way can match.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, else the oldest way of the set.
    always_comb begin
        victim_way = lru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[set_idx][w]) victim_way = AGE_W'(w);
        end
    end

    assign touch_way = (state_q == RD) ? victim_q : hit_way;

    l2_lru_age #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
        .age_in    (age_q[set_idx]),
        .touch_way (touch_way),
        .age_out   (age_next),
        .lru_way   (lru_way)
    );

    assign hit_line   = data_q[set_idx][hit_way];
    assign proc_rdata = hit_line[word_sel*WORD_W +: WORD_W];
    assign proc_stall = ((proc_read | proc_write) & ~hit) | (state_q != IDLE);

    // Flush pointer walks way-minor; way wrap carries into the set.
    assign fl_last   = (fl_set_q == IDX_W'(SETS - 1)) && (fl_way_q == AGE_W'(WAYS - 1));
    assign fl_way_nx = fl_way_q + 1'b1;
    assign fl_set_nx = (fl_way_q == AGE_W'(WAYS - 1)) ? fl_set_q + 1'b1 : fl_set_q;

    // Next-state, registered memory request values and array update strobes.
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        fl_set_d     = fl_set_q;
        fl_way_d     = fl_way_q;
        mem_read_d   = mem_read;
        mem_write_d  = mem_write;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        flush_done_d = 1'b0;
        hit_touch_en = 1'b0;
        hit_wr_en    = 1'b0;
        fill_en      = 1'b0;
        fl_clean_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (proc_read || proc_write) begin
                    if (hit) begin
                        hit_touch_en = 1'b1;
                        hit_wr_en    = proc_write;
                    end else begin
                        victim_d = victim_way;
                        if (valid_q[set_idx][victim_way] && dirty_q[set_idx][victim_way]) begin
                            state_d     = WB;
                            mem_write_d = 1'b1;
                            mem_addr_d  = {tag_q[set_idx][victim_way], set_idx};
                            mem_wdata_d = data_q[set_idx][victim_way];
                        end else begin
                            state_d    = RD;
                            mem_read_d = 1'b1;
                            mem_addr_d = proc_addr[ADDR_W-1:OFFSET_W];
                        end
                    end
                end else if (flush) begin
                    state_d  = FL;
                    fl_set_d = '0;
                    fl_way_d = '0;
                end
            end
            WB: begin
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = proc_addr[ADDR_W-1:OFFSET_W];
                    state_d     = RD;
                end
            end
            RD: begin
                if (mem_ready) begin
                    mem_read_d = 1'b0;
                    fill_en    = 1'b1;
                    state_d    = IDLE;
                end
            end
            FL: begin
                if (dirty_q[fl_set_q][fl_way_q]) begin
                    state_d     = FLWB;
                    mem_write_d = 1'b1;
                    mem_addr_d  = {tag_q[fl_set_q][fl_way_q], fl_set_q};
                    mem_wdata_d = data_q[fl_set_q][fl_way_q];
                end else if (fl_last) begin
                    flush_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    fl_set_d = fl_set_nx;
                    fl_way_d = fl_way_nx;
                end
            end
            FLWB: begin
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    fl_clean_en = 1'b1;
                    if (fl_last) begin
                        flush_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        fl_set_d = fl_set_nx;
                        fl_way_d = fl_way_nx;
                        state_d  = FL;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and registered memory-side outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q    <= IDLE;
            victim_q   <= '0;
            fl_set_q   <= '0;
            fl_way_q   <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            flush_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            fl_set_q   <= fl_set_d;
            fl_way_q   <= fl_way_d;
            mem_read   <= mem_read_d;
            mem_write  <= mem_write_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            flush_done <= flush_done_d;
        end
    end

    // Valid, dirty and age bookkeeping; these are the only array bits that reset.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
            end
        end else begin
            if (hit_touch_en) begin
                age_q[set_idx] <= age_next;
                if (hit_wr_en) dirty_q[set_idx][hit_way] <= 1'b1;
            end
            if (fill_en) begin
                valid_q[set_idx][victim_q] <= 1'b1;
                dirty_q[set_idx][victim_q] <= proc_write;
                age_q[set_idx]             <= age_next;
            end
            if (fl_clean_en) dirty_q[fl_set_q][fl_way_q] <= 1'b0;
        end
    end

    // Tag and line data writes on fills and write hits.
    // NOTE: tag/data arrays have no reset; a cleared valid bit makes their contents irrelevant and keeps them RAM-mappable.
    always_ff @(posedge clk) begin
        if (!proc_reset) begin
            if (hit_wr_en) data_q[set_idx][hit_way] <= merge_word(hit_line, word_sel, proc_wdata);
            if (fill_en) begin
                tag_q[set_idx][victim_q]  <= tag;
                data_q[set_idx][victim_q] <= proc_write ? merge_word(mem_rdata, word_sel, proc_wdata)
                                                        : mem_rdata;
            end
        end
    end

endmodule
